pc_stack: RTL and testbench

- Parametrised program counter for the CPU fetch path. Generalised successor to the 8-bit PC.
- Adds configurable address width, signed relative branch, and a hardware call/return stack of configurable depth.
- Reports stack depth and full/empty status, plus a sticky error flag.
- Drives the instruction-memory address; the control unit drives the command strobes.

---
 rtl/pc_stack.sv | 93 +++++++++
 tb/tb_pc_stack.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack.sv
// Program counter with signed relative branch and a hardware call/return stack.
// One command per rising edge, priority CLR > LD > BR > CALL > RET > IPC.
module pc_stack #(
  parameter int             W         = 8,
  parameter int             OW        = 4,
  parameter int             DEPTH     = 4,
  parameter logic [W-1:0]   RESET_VAL = '0,
  localparam int            LW        = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          IPC,
  input  logic          LD,
  input  logic          BR,
  input  logic          CALL,
  input  logic          RET,
  input  logic [W-1:0]  D,
  input  logic [OW-1:0] OFS,
  output logic [W-1:0]  Q,
  output logic [LW-1:0] LVL,
  output logic          FULL,
  output logic          EMPTY,
  output logic          ERR
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  stack_mem [DEPTH];
  logic [W-1:0]  q_next;
  logic [LW-1:0] lvl_next;
  logic          err_next;
  logic          push;
  logic [W-1:0]  ofs_ext;
  logic [W-1:0]  ret_addr;
  logic [W-1:0]  top_val;
  logic [LW-1:0] top_lvl;
  logic [AW-1:0] push_idx;
  logic [AW-1:0] top_idx;

  assign FULL     = (LVL == LW'(DEPTH));
  assign EMPTY    = (LVL == '0);
  assign ofs_ext  = W'($signed(OFS));
  assign ret_addr = Q + W'(1);
  assign top_lvl  = LVL - LW'(1);
  assign push_idx = AW'(LVL);
  assign top_idx  = AW'(top_lvl);
  assign top_val  = stack_mem[top_idx];

  always_comb begin
    q_next   = Q;
    lvl_next = LVL;
    err_next = ERR;
    push     = 1'b0;
    if (CLR) begin
      q_next   = RESET_VAL;
      lvl_next = '0;
      err_next = 1'b0;
    end else if (LD) begin
      q_next = D;
    end else if (BR) begin
      q_next = Q + ofs_ext;
    end else if (CALL) begin
      if (FULL) begin
        err_next = 1'b1;
      end else begin
        push     = 1'b1;
        q_next   = D;
        lvl_next = LVL + LW'(1);
      end
    end else if (RET) begin
      if (EMPTY) begin
        err_next = 1'b1;
      end else begin
        q_next   = top_val;
        lvl_next = top_lvl;
      end
    end else if (IPC) begin
      q_next = Q + W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    Q   <= q_next;
    LVL <= lvl_next;
    ERR <= err_next;
  end

  // Storage is never cleared; only LVL decides which entries are meaningful.
  always_ff @(posedge CLK) begin
    if (push) stack_mem[push_idx] <= ret_addr;
  end

endmodule

// File: tb/tb_pc_stack.sv
// Directed self-checking bench for pc_stack with W=8, OW=4, DEPTH=4, RESET_VAL=0.
module tb_pc_stack;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0, IPC = 1'b0, LD = 1'b0, BR = 1'b0, CALL = 1'b0, RET = 1'b0;
  logic [7:0] D   = 8'h00;
  logic [3:0] OFS = 4'h0;
  logic [7:0] Q;
  logic [2:0] LVL;
  logic       FULL, EMPTY, ERR;

  int checks   = 0;
  int failures = 0;

  pc_stack #(.W(8), .OW(4), .DEPTH(4), .RESET_VAL(8'h00)) dut (
    .CLK(CLK), .CLR(CLR), .IPC(IPC), .LD(LD), .BR(BR), .CALL(CALL), .RET(RET),
    .D(D), .OFS(OFS), .Q(Q), .LVL(LVL), .FULL(FULL), .EMPTY(EMPTY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Apply one cycle of strobes, let the edge happen, sample 1 ns later, then idle.
  task automatic cmd(input logic clr, ld, br, call, ret, ipc,
                     input logic [7:0] d, input logic [3:0] ofs);
    CLR = clr; LD = ld; BR = br; CALL = call; RET = ret; IPC = ipc; D = d; OFS = ofs;
    @(posedge CLK);
    #1;
    CLR = 0; LD = 0; BR = 0; CALL = 0; RET = 0; IPC = 0;
  endtask

  task automatic test_reset;
    cmd(1, 0, 0, 0, 0, 0, 8'h00, 4'h0);
    checks++;
    if (Q !== 8'h00 || LVL !== 3'd0 || ERR !== 1'b0 || EMPTY !== 1'b1 || FULL !== 1'b0) begin
      failures++;
      $display("FAIL reset Q=%h LVL=%0d ERR=%b EMPTY=%b FULL=%b exp Q=00 LVL=0 ERR=0 EMPTY=1 FULL=0",
               Q, LVL, ERR, EMPTY, FULL);
    end
  endtask

  task automatic test_increment;
    logic [7:0] exp_q [3] = '{8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 3; i++) begin
      cmd(0, 0, 0, 0, 0, 1, 8'h00, 4'h0);
      checks++;
      if (Q !== exp_q[i] || LVL !== 3'd0 || EMPTY !== 1'b1 || ERR !== 1'b0) begin
        failures++;
        $display("FAIL ipc_%0d Q=%h LVL=%0d EMPTY=%b ERR=%b exp Q=%h LVL=0 EMPTY=1 ERR=0",
                 i, Q, LVL, EMPTY, ERR, exp_q[i]);
      end
    end
    cmd(0, 0, 0, 0, 0, 0, 8'h00, 4'h0);
    checks++;
    if (Q !== 8'h03) begin
      failures++;
      $display("FAIL hold Q=%h exp=03", Q);
    end
    cmd(0, 1, 0, 0, 0, 0, 8'hFF, 4'h0);
    cmd(0, 0, 0, 0, 0, 1, 8'h00, 4'h0);
    checks++;
    if (Q !== 8'h00) begin
      failures++;
      $display("FAIL ipc_wrap Q=%h exp=00", Q);
    end
  endtask

  task automatic test_load_branch;
    cmd(0, 1, 0, 0, 0, 0, 8'h10, 4'h0);
    cmd(0, 1, 1, 0, 0, 1, 8'h0F, 4'h3);
    checks++;
    if (Q !== 8'h0F) begin
      failures++;
      $display("FAIL ld_priority Q=%h exp=0F", Q);
    end
    cmd(0, 0, 1, 0, 0, 0, 8'h00, 4'b1101);
    checks++;
    if (Q !== 8'h0C) begin
      failures++;
      $display("FAIL br_neg Q=%h exp=0C", Q);
    end
    cmd(0, 0, 1, 0, 0, 0, 8'h00, 4'b0111);
    checks++;
    if (Q !== 8'h13) begin
      failures++;
      $display("FAIL br_pos Q=%h exp=13", Q);
    end
    cmd(0, 1, 0, 0, 0, 0, 8'h02, 4'h0);
    cmd(0, 0, 1, 0, 0, 0, 8'h00, 4'b1101);
    checks++;
    if (Q !== 8'hFF) begin
      failures++;
      $display("FAIL br_wrap Q=%h exp=FF", Q);
    end
  endtask

  task automatic test_priority;
    cmd(0, 1, 0, 0, 0, 0, 8'h13, 4'h0);
    cmd(0, 0, 1, 1, 0, 0, 8'h80, 4'h1);
    checks++;
    if (Q !== 8'h14 || LVL !== 3'd0) begin
      failures++;
      $display("FAIL br_over_call Q=%h LVL=%0d exp Q=14 LVL=0", Q, LVL);
    end
    cmd(0, 0, 0, 1, 1, 1, 8'h80, 4'h0);
    checks++;
    if (Q !== 8'h80 || LVL !== 3'd1) begin
      failures++;
      $display("FAIL call_over_ret Q=%h LVL=%0d exp Q=80 LVL=1", Q, LVL);
    end
    cmd(0, 0, 0, 0, 1, 1, 8'h00, 4'h0);
    checks++;
    if (Q !== 8'h15 || LVL !== 3'd0 || ERR !== 1'b0) begin
      failures++;
      $display("FAIL ret_over_ipc Q=%h LVL=%0d ERR=%b exp Q=15 LVL=0 ERR=0", Q, LVL, ERR);
    end
  endtask

  task automatic test_nested_call;
    cmd(0, 1, 0, 0, 0, 0, 8'h20, 4'h0);
    cmd(0, 0, 0, 1, 0, 0, 8'h40, 4'h0);
    checks++;
    if (Q !== 8'h40 || LVL !== 3'd1 || EMPTY !== 1'b0) begin
      failures++;
      $display("FAIL call1 Q=%h LVL=%0d EMPTY=%b exp Q=40 LVL=1 EMPTY=0", Q, LVL, EMPTY);
    end
    cmd(0, 0, 0, 1, 0, 0, 8'h60, 4'h0);
    checks++;
    if (Q !== 8'h60 || LVL !== 3'd2) begin
      failures++;
      $display("FAIL call2 Q=%h LVL=%0d exp Q=60 LVL=2", Q, LVL);
    end
    cmd(0, 0, 0, 0, 1, 0, 8'h00, 4'h0);
    checks++;
    if (Q !== 8'h41 || LVL !== 3'd1) begin
      failures++;
      $display("FAIL ret1 Q=%h LVL=%0d exp Q=41 LVL=1", Q, LVL);
    end
    cmd(0, 0, 0, 0, 1, 0, 8'h00, 4'h0);
    checks++;
    if (Q !== 8'h21 || LVL !== 3'd0 || EMPTY !== 1'b1 || ERR !== 1'b0) begin
      failures++;
      $display("FAIL ret2 Q=%h LVL=%0d EMPTY=%b ERR=%b exp Q=21 LVL=0 EMPTY=1 ERR=0",
               Q, LVL, EMPTY, ERR);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] tgt   [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    logic [7:0] ret_q [4] = '{8'h31, 8'h21, 8'h11, 8'h01};
    cmd(1, 0, 0, 0, 0, 0, 8'h00, 4'h0);
    for (int i = 0; i < 4; i++) begin
      cmd(0, 0, 0, 1, 0, 0, tgt[i], 4'h0);
      checks++;
      if (Q !== tgt[i] || LVL !== 3'(i + 1) || FULL !== (i == 3)) begin
        failures++;
        $display("FAIL push_%0d Q=%h LVL=%0d FULL=%b exp Q=%h LVL=%0d FULL=%b",
                 i, Q, LVL, FULL, tgt[i], i + 1, (i == 3));
      end
    end
    cmd(0, 0, 0, 1, 0, 0, 8'h50, 4'h0);
    checks++;
    if (Q !== 8'h40 || LVL !== 3'd4 || FULL !== 1'b1 || ERR !== 1'b1) begin
      failures++;
      $display("FAIL overflow Q=%h LVL=%0d FULL=%b ERR=%b exp Q=40 LVL=4 FULL=1 ERR=1",
               Q, LVL, FULL, ERR);
    end
    for (int i = 0; i < 4; i++) begin
      cmd(0, 0, 0, 0, 1, 0, 8'h00, 4'h0);
      checks++;
      if (Q !== ret_q[i] || LVL !== 3'(3 - i) || ERR !== 1'b1) begin
        failures++;
        $display("FAIL pop_%0d Q=%h LVL=%0d ERR=%b exp Q=%h LVL=%0d ERR=1",
                 i, Q, LVL, ERR, ret_q[i], 3 - i);
      end
    end
  endtask

  task automatic test_underflow;
    cmd(1, 0, 0, 0, 0, 0, 8'h00, 4'h0);
    cmd(0, 0, 0, 0, 1, 0, 8'h00, 4'h0);
    checks++;
    if (Q !== 8'h00 || LVL !== 3'd0 || ERR !== 1'b1 || EMPTY !== 1'b1) begin
      failures++;
      $display("FAIL underflow Q=%h LVL=%0d ERR=%b EMPTY=%b exp Q=00 LVL=0 ERR=1 EMPTY=1",
               Q, LVL, ERR, EMPTY);
    end
    cmd(0, 0, 0, 0, 0, 1, 8'h00, 4'h0);
    checks++;
    if (Q !== 8'h01 || ERR !== 1'b1) begin
      failures++;
      $display("FAIL after_err Q=%h ERR=%b exp Q=01 ERR=1", Q, ERR);
    end
    cmd(1, 0, 0, 0, 0, 0, 8'h00, 4'h0);
    checks++;
    if (ERR !== 1'b0 || Q !== 8'h00) begin
      failures++;
      $display("FAIL err_clear ERR=%b Q=%h exp ERR=0 Q=00", ERR, Q);
    end
  endtask

  task automatic test_reset_mid_op;
    cmd(0, 1, 0, 0, 0, 0, 8'h10, 4'h0);
    cmd(0, 0, 0, 1, 0, 0, 8'h20, 4'h0);
    cmd(0, 0, 0, 1, 0, 0, 8'h30, 4'h0);
    cmd(0, 0, 0, 1, 0, 0, 8'h54, 4'h0);
    cmd(0, 0, 0, 0, 0, 1, 8'h00, 4'h0);
    checks++;
    if (Q !== 8'h55 || LVL !== 3'd3) begin
      failures++;
      $display("FAIL mid_setup Q=%h LVL=%0d exp Q=55 LVL=3", Q, LVL);
    end
    cmd(1, 0, 0, 1, 0, 0, 8'h77, 4'h0);
    checks++;
    if (Q !== 8'h00 || LVL !== 3'd0 || ERR !== 1'b0 || EMPTY !== 1'b1 || FULL !== 1'b0) begin
      failures++;
      $display("FAIL clr_wins Q=%h LVL=%0d ERR=%b EMPTY=%b FULL=%b exp Q=00 LVL=0 ERR=0 EMPTY=1 FULL=0",
               Q, LVL, ERR, EMPTY, FULL);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_increment();
    test_load_branch();
    test_priority();
    test_nested_call();
    test_overflow();
    test_underflow();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
